id_ex_skid_stage: RTL

//   Parametrised ID->EX pipeline stage register with valid/ready handshake and a
//   2-entry skid buffer. It carries the decoded instruction, operands, destination

---
 rtl/id_ex_skid_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with valid/ready handshake, a 2-entry skid buffer,
// flush/hold control and a saturating upstream-stall counter.
module id_ex_skid_stage #(
   parameter int CPU_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int CTRL_WIDTH      = 5,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       hold,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CPU_WIDTH-1:0]       in_instruction,
   input  logic [CPU_WIDTH-1:0]       in_data_a,
   input  logic [CPU_WIDTH-1:0]       in_data_b,
   input  logic [REG_ADDR_WIDTH-1:0]  in_destination_register,
   input  logic [CTRL_WIDTH-1:0]      in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CPU_WIDTH-1:0]       out_instruction,
   output logic [CPU_WIDTH-1:0]       out_data_a,
   output logic [CPU_WIDTH-1:0]       out_data_b,
   output logic [REG_ADDR_WIDTH-1:0]  out_destination_register,
   output logic [CTRL_WIDTH-1:0]      out_ctrl,
   output logic [1:0]                 occupancy,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);

   localparam int PW = 3 * CPU_WIDTH + REG_ADDR_WIDTH + CTRL_WIDTH;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t        state_q;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic [PW-1:0] in_pl;
   logic          accept;
   logic          drain;

   function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Control bits sit in the low bits so flush can clear them without touching the rest.
   assign in_pl = {in_instruction, in_data_a, in_data_b, in_destination_register, in_ctrl};

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready & ~hold;

   assign out_valid = (state_q != EMPTY);
   assign occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

   assign out_instruction          = main_q[PW-1 -: CPU_WIDTH];
   assign out_data_a               = main_q[PW-CPU_WIDTH-1 -: CPU_WIDTH];
   assign out_data_b               = main_q[PW-2*CPU_WIDTH-1 -: CPU_WIDTH];
   assign out_destination_register = main_q[CTRL_WIDTH +: REG_ADDR_WIDTH];
   assign out_ctrl                 = out_valid ? main_q[CTRL_WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready    <= 1'b1;
         main_q      <= '0;
         skid_q      <= '0;
         stall_count <= '0;
      end else begin
         if (in_valid && !in_ready)
            stall_count <= sat_inc(stall_count);

         if (flush) begin
            state_q                <= EMPTY;
            in_ready               <= 1'b1;
            main_q[CTRL_WIDTH-1:0] <= '0;
            skid_q[CTRL_WIDTH-1:0] <= '0;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (accept) begin
                     main_q  <= in_pl;
                     state_q <= ONE;
                  end
               end
               ONE: begin
                  if (accept && drain) begin
                     main_q <= in_pl;
                  end else if (accept) begin
                     skid_q   <= in_pl;
                     state_q  <= FULL;
                     in_ready <= 1'b0;
                  end else if (drain) begin
                     state_q <= EMPTY;
                  end
               end
               FULL: begin
                  if (drain) begin
                     main_q   <= skid_q;
                     state_q  <= ONE;
                     in_ready <= 1'b1;
                  end
               end
               default: begin
                  state_q  <= EMPTY;
                  in_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
